// File: rtl/uart_bus_interface.sv
// Avalon-MM 8N1 UART with a programmable clocks-per-bit divider; reads are zero-wait, and DATA writes stall while a frame is in flight.
// The receiver and its status bits exist only when UART_RX_EN is defined; otherwise i_Rx is ignored and the RX fields read 0.
module uart_bus_interface #(
    parameter int NUM_PERIPH_SEL_BITS = 5,
    parameter int PERIPH_SEL          = 0
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [29:0] i_AV_Addr,
    input  logic [3:0]  i_AV_ByteEn,
    input  logic        i_AV_Read,
    output logic [31:0] o_AV_ReadData,
    input  logic        i_AV_Write,
    input  logic [31:0] i_AV_WriteData,
    output logic        o_AV_WaitRequest,
    input  logic [10:0] i_AV_BurstCount,
    output logic        o_Tx,
    input  logic        i_Rx
);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic [15:0] r_div;
    logic        r_tx_en;
    tx_state_t   r_tx_state;
    logic        r_tx;
    logic        r_tx_busy;
    logic [15:0] r_tx_cnt;
    logic [15:0] r_tx_bdiv;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_shift;

    logic        w_sel;
    logic        w_rd;
    logic        w_wr_accept;
    logic        w_ctrl_wr;
    logic        w_tx_load;
    logic        w_tx_bit_end;
    logic [15:0] w_div_eff;
    logic [31:0] w_ctrl_rd;
    logic        w_rx_en;
    logic        w_rx_vld;
    logic        w_rx_ovr;
    logic        w_rx_ferr;
    logic [7:0]  w_rx_byte;
    logic        w_unused;

    assign w_sel     = (i_AV_Addr[29 -: NUM_PERIPH_SEL_BITS] == NUM_PERIPH_SEL_BITS'(PERIPH_SEL));
    assign w_rd      = w_sel & i_AV_Read & ~i_AV_Write;
    assign w_div_eff = (r_div == 16'd0) ? 16'd1 : r_div;

    // Only a write that would actually load the transmitter waits for it.
    assign o_AV_WaitRequest = w_sel & i_AV_Write & i_AV_Addr[0] & i_AV_ByteEn[0]
                            & r_tx_en & r_tx_busy;

    assign w_wr_accept  = w_sel & i_AV_Write & ~o_AV_WaitRequest;
    assign w_ctrl_wr    = w_wr_accept & ~i_AV_Addr[0];
    assign w_tx_load    = w_wr_accept & i_AV_Addr[0] & i_AV_ByteEn[0] & r_tx_en;
    assign w_tx_bit_end = (r_tx_cnt == r_tx_bdiv - 16'd1);

    assign w_unused = &{1'b0, i_AV_BurstCount, i_AV_Addr, i_AV_ByteEn[3], i_AV_WriteData, i_Rx};

    assign w_ctrl_rd = {10'b0, w_rx_ferr, w_rx_ovr, w_rx_vld, r_tx_busy, w_rx_en, r_tx_en, r_div};

    always_comb begin
        o_AV_ReadData = 32'd0;
        if (w_rd) begin
            if (i_AV_Addr[0])
                o_AV_ReadData = {24'd0, w_rx_byte};
            else
                o_AV_ReadData = w_ctrl_rd;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_div   <= 16'd0;
            r_tx_en <= 1'b0;
        end else if (w_ctrl_wr) begin
            if (i_AV_ByteEn[0]) r_div[7:0]  <= i_AV_WriteData[7:0];
            if (i_AV_ByteEn[1]) r_div[15:8] <= i_AV_WriteData[15:8];
            if (i_AV_ByteEn[2]) r_tx_en     <= i_AV_WriteData[16];
        end
    end

    // The bit period is latched at every bit boundary so DIV edits never stretch a bit in progress.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_tx_state <= TX_IDLE;
            r_tx       <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_cnt   <= 16'd0;
            r_tx_bdiv  <= 16'd1;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'd0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_load) begin
                        r_tx_state <= TX_START;
                        r_tx       <= 1'b0;
                        r_tx_busy  <= 1'b1;
                        r_tx_cnt   <= 16'd0;
                        r_tx_bdiv  <= w_div_eff;
                        r_tx_shift <= i_AV_WriteData[7:0];
                    end
                end
                TX_START: begin
                    if (w_tx_bit_end) begin
                        r_tx_state <= TX_DATA;
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_bit   <= 3'd0;
                        r_tx_cnt   <= 16'd0;
                        r_tx_bdiv  <= w_div_eff;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt  <= 16'd0;
                        r_tx_bdiv <= w_div_eff;
                        if (r_tx_bit == 3'd7) begin
                            r_tx_state <= TX_STOP;
                            r_tx       <= 1'b1;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 3'd1;
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (w_tx_bit_end) begin
                        r_tx_state <= TX_IDLE;
                        r_tx_busy  <= 1'b0;
                        r_tx_cnt   <= 16'd0;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                default: begin
                    r_tx_state <= TX_IDLE;
                    r_tx       <= 1'b1;
                    r_tx_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_Tx = r_tx;

`ifdef UART_RX_EN
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t   r_rx_state;
    logic        r_rx_en;
    logic        r_rx_meta;
    logic        r_rx_sync;
    logic        r_rx_prev;
    logic [15:0] r_rx_cnt;
    logic [15:0] r_rx_bdiv;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic [7:0]  r_rx_byte;
    logic        r_rx_valid;
    logic        r_rx_ovr;
    logic        r_rx_ferr;

    logic        w_rx_bit_end;
    logic        w_rx_mid;
    logic        w_rx_done;
    logic        w_data_rd;

    assign w_rx_bit_end = (r_rx_cnt == r_rx_bdiv - 16'd1);
    assign w_rx_mid     = (r_rx_cnt == (r_rx_bdiv >> 1));
    assign w_rx_done    = r_rx_en & (r_rx_state == RX_STOP) & w_rx_bit_end;
    assign w_data_rd    = w_rd & i_AV_Addr[0];

    always_ff @(posedge i_Clk) begin
        if (i_Rst)
            r_rx_en <= 1'b0;
        else if (w_ctrl_wr && i_AV_ByteEn[2])
            r_rx_en <= i_AV_WriteData[17];
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= 16'd0;
            r_rx_bdiv  <= 16'd1;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'd0;
        end else begin
            r_rx_meta <= i_Rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            if (!r_rx_en) begin
                r_rx_state <= RX_IDLE;
                r_rx_cnt   <= 16'd0;
            end else begin
                case (r_rx_state)
                    RX_IDLE: begin
                        if (r_rx_prev && !r_rx_sync) begin
                            r_rx_state <= RX_START;
                            r_rx_cnt   <= 16'd0;
                            r_rx_bdiv  <= w_div_eff;
                        end
                    end
                    RX_START: begin
                        if (w_rx_mid) begin
                            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                            r_rx_cnt   <= 16'd0;
                            r_rx_bit   <= 3'd0;
                            r_rx_bdiv  <= w_div_eff;
                        end else begin
                            r_rx_cnt <= r_rx_cnt + 16'd1;
                        end
                    end
                    RX_DATA: begin
                        if (w_rx_bit_end) begin
                            r_rx_cnt   <= 16'd0;
                            r_rx_bdiv  <= w_div_eff;
                            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                            if (r_rx_bit == 3'd7)
                                r_rx_state <= RX_STOP;
                            else
                                r_rx_bit <= r_rx_bit + 3'd1;
                        end else begin
                            r_rx_cnt <= r_rx_cnt + 16'd1;
                        end
                    end
                    RX_STOP: begin
                        if (w_rx_bit_end) begin
                            r_rx_state <= RX_IDLE;
                            r_rx_cnt   <= 16'd0;
                        end else begin
                            r_rx_cnt <= r_rx_cnt + 16'd1;
                        end
                    end
                    default: r_rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    // A completing byte beats a simultaneous DATA read, so the new byte is never lost.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_rx_byte  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_rx_ovr   <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else if (w_rx_done) begin
            r_rx_byte  <= r_rx_shift;
            r_rx_valid <= 1'b1;
            r_rx_ovr   <= r_rx_valid | (r_rx_ovr & ~w_data_rd);
            r_rx_ferr  <= ~r_rx_sync;
        end else if (w_data_rd) begin
            r_rx_valid <= 1'b0;
            r_rx_ovr   <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end
    end

    assign w_rx_en   = r_rx_en;
    assign w_rx_vld  = r_rx_valid;
    assign w_rx_ovr  = r_rx_ovr;
    assign w_rx_ferr = r_rx_ferr;
    assign w_rx_byte = r_rx_byte;
`else
    assign w_rx_en   = 1'b0;
    assign w_rx_vld  = 1'b0;
    assign w_rx_ovr  = 1'b0;
    assign w_rx_ferr = 1'b0;
    assign w_rx_byte = 8'd0;
`endif

endmodule

// File: tb/tb_uart_bus_interface.sv
// Directed bench for uart_bus_interface: bus decode, TX framing and stalls, and (with UART_RX_EN) loopback receive.
module tb_uart_bus_interface;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] addr;
    logic [3:0]  be;
    logic        rd;
    logic [31:0] rdata;
    logic        wr;
    logic [31:0] wdata;
    logic        waitreq;
    logic [10:0] burst;
    logic        tx;
    wire         rx_w;
    logic        loop_en;
    logic        rx_drv;

    int checks = 0;
    int errors = 0;

`ifdef UART_RX_EN
    localparam logic [31:0] RXEN_BIT = 32'h0002_0000;
`else
    localparam logic [31:0] RXEN_BIT = 32'h0000_0000;
`endif
    localparam logic [29:0] A_CTRL  = 30'h0000_0000;
    localparam logic [29:0] A_DATA  = 30'h0000_0001;
    localparam logic [29:0] A_OTHER = 30'h0200_0000;

    always #5 clk = ~clk;
    assign rx_w = loop_en ? tx : rx_drv;

    uart_bus_interface #(.NUM_PERIPH_SEL_BITS(5), .PERIPH_SEL(0)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_AV_Addr(addr), .i_AV_ByteEn(be),
        .i_AV_Read(rd), .o_AV_ReadData(rdata), .i_AV_Write(wr),
        .i_AV_WriteData(wdata), .o_AV_WaitRequest(waitreq),
        .i_AV_BurstCount(burst), .o_Tx(tx), .i_Rx(rx_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] b,
                             output int stalls);
        @(negedge clk);
        addr = a; wdata = d; be = b; wr = 1'b1; rd = 1'b0;
        stalls = 0;
        #1;
        while (waitreq && stalls < 5000) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        @(posedge clk);
        #1;
        wr = 1'b0; be = 4'h0; addr = '0; wdata = '0;
    endtask

    task automatic bus_read(input logic [29:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; rd = 1'b1; wr = 1'b0;
        #1;
        d = rdata;
        @(posedge clk);
        #1;
        rd = 1'b0; addr = '0;
    endtask

    // Called just after the accepting edge; checks o_Tx and TX_BUSY on every clock of the frame.
    task automatic check_frame(input logic [7:0] b, input int div, input string tag);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        addr = A_CTRL; rd = 1'b1;
        for (int k = 0; k < 10 * div; k++) begin
            @(negedge clk);
            check(tag, {30'd0, tx, rdata[18]}, {30'd0, bits[k / div], 1'b1});
        end
        @(negedge clk);
        check({tag, "_end"}, {30'd0, tx, rdata[18]}, {30'd0, 1'b1, 1'b0});
        rd = 1'b0;
    endtask

    task automatic check_idle(input int n, input string tag);
        addr = A_CTRL; rd = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check(tag, {30'd0, tx, rdata[18]}, {30'd0, 1'b1, 1'b0});
        end
        rd = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          st;
        logic [31:0] d;

        rst = 1'b1; addr = '0; be = '0; rd = 1'b0; wr = 1'b0; wdata = '0;
        burst = 11'd1; loop_en = 1'b0; rx_drv = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        #1;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_waitreq", {31'd0, waitreq}, 32'd0);
        check("rst_rdata_idle", rdata, 32'd0);
        bus_read(A_CTRL, d);
        check("rst_ctrl", d, 32'd0);

        // CTRL then DATA on consecutive edges, 0x48 at 10 clocks per bit.
        bus_write(A_CTRL, 32'h0003_000A, 4'hF, st);
        check("ctrl_wr_stall", st, 0);
        bus_write(A_DATA, 32'h0000_0048, 4'hF, st);
        check("data_wr_stall", st, 0);
        check_frame(8'h48, 10, "frame48");
        bus_read(A_CTRL, d);
        check("ctrl_readback", d, 32'h0001_000A | RXEN_BIT);

        // Second write lands right after a frame starts and must wait it out.
        bus_write(A_DATA, 32'h0000_0033, 4'h1, st);
        check("first_wr_stall", st, 0);
        bus_write(A_DATA, 32'h0000_0055, 4'h1, st);
        check("stalled_wr_cycles", st, 100);
        check_frame(8'h55, 10, "frame55");

        // DIV=0 behaves as DIV=1; byte enables 0/1 only.
        bus_write(A_CTRL, 32'hFFFF_0000, 4'h3, st);
        bus_read(A_CTRL, d);
        check("div0_ctrl", d, 32'h0001_0000 | RXEN_BIT);
        bus_write(A_DATA, 32'h0000_0081, 4'h1, st);
        check_frame(8'h81, 1, "frame81_div1");

        // Single byte-lane write to DIV[7:0].
        bus_write(A_CTRL, 32'h0000_FF0A, 4'h1, st);
        bus_read(A_CTRL, d);
        check("be0_ctrl", d, 32'h0001_000A | RXEN_BIT);

        // Accesses outside this peripheral's select value.
        bus_write(A_OTHER, 32'hFFFF_FFFF, 4'hF, st);
        check("unsel_wr_stall", st, 0);
        bus_read(A_OTHER, d);
        check("unsel_rdata", d, 32'd0);
        bus_write(A_OTHER | A_DATA, 32'h0000_0012, 4'hF, st);
        check("unsel_data_stall", st, 0);
        check_idle(20, "unsel_idle");
        bus_read(A_CTRL, d);
        check("unsel_ctrl_kept", d, 32'h0001_000A | RXEN_BIT);

        // Read and write together: write wins, read data 0.
        @(negedge clk);
        addr = A_CTRL; rd = 1'b1; wr = 1'b1; wdata = 32'h0000_0014; be = 4'h1;
        #1;
        check("rdwr_rdata", rdata, 32'd0);
        check("rdwr_waitreq", {31'd0, waitreq}, 32'd0);
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0; be = 4'h0; wdata = '0;
        bus_read(A_CTRL, d);
        check("rdwr_ctrl", d, 32'h0001_0014 | RXEN_BIT);

        // TX_EN=0: DATA write is accepted without stall and dropped.
        bus_write(A_CTRL, 32'h0000_0000, 4'h4, st);
        bus_write(A_DATA, 32'h0000_0099, 4'h1, st);
        check("txdis_stall", st, 0);
        check_idle(30, "txdis_idle");
        bus_read(A_CTRL, d);
        check("txdis_ctrl", d, 32'h0000_0014);

`ifdef UART_RX_EN
        bus_write(A_CTRL, 32'h0003_000A, 4'hF, st);
        loop_en = 1'b1;
        bus_write(A_DATA, 32'h0000_00A5, 4'h1, st);
        repeat (110) @(negedge clk);
        bus_read(A_CTRL, d);
        check("rx_valid_ctrl", d, 32'h000B_000A);
        bus_read(A_DATA, d);
        check("rx_data_a5", d, 32'h0000_00A5);
        bus_read(A_CTRL, d);
        check("rx_cleared_ctrl", d, 32'h0003_000A);

        bus_write(A_DATA, 32'h0000_003C, 4'h1, st);
        bus_write(A_DATA, 32'h0000_005A, 4'h1, st);
        check("rx_second_stall", st, 100);
        repeat (110) @(negedge clk);
        bus_read(A_CTRL, d);
        check("rx_overrun_ctrl", d, 32'h001B_000A);
        bus_read(A_DATA, d);
        check("rx_overrun_data", d, 32'h0000_005A);
        bus_read(A_CTRL, d);
        check("rx_overrun_cleared", d, 32'h0003_000A);

        // Hand-driven frame of 0xFF with a low stop bit.
        loop_en = 1'b0;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (10) @(negedge clk);
        rx_drv = 1'b1;
        repeat (80) @(negedge clk);
        rx_drv = 1'b0;
        repeat (10) @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        bus_read(A_CTRL, d);
        check("rx_frame_err_ctrl", d, 32'h002B_000A);
        bus_read(A_DATA, d);
        check("rx_frame_err_data", d, 32'h0000_00FF);
`else
        bus_write(A_CTRL, 32'h0003_000A, 4'hF, st);
        bus_read(A_DATA, d);
        check("norx_data_rd", d, 32'd0);
        bus_read(A_CTRL, d);
        check("norx_ctrl", d, 32'h0001_000A);
`endif

        // Reset in the middle of a frame.
        bus_write(A_CTRL, 32'h0001_000A, 4'hF, st);
        bus_write(A_DATA, 32'h0000_0000, 4'h1, st);
        repeat (5) @(negedge clk);
        check("midframe_tx_low", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midframe_rst_tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bus_read(A_CTRL, d);
        check("midframe_rst_ctrl", d, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_bus_interface.md
# uart_bus_interface

Avalon-MM slave wrapping an 8N1 UART transmitter/receiver with a programmable bit-rate divider. Sits on the SoC peripheral bus. It decodes its own peripheral-select field from the word address and exposes a control/status register and a data register to the CPU.

## Interface
- NUM_PERIPH_SEL_BITS, 5: width of the peripheral-select field, taken from the top of i_AV_Addr.
- PERIPH_SEL, 0: select value that maps this instance.
- i_Clk in 1: system clock. The block has one clock.
- i_Rst in 1: reset, synchronous and active-high.
- i_AV_Addr in 30: word address.
  - [29 -: NUM_PERIPH_SEL_BITS] must equal PERIPH_SEL for the block to respond.
  - [0] selects the register: 0 = CTRL, 1 = DATA.
  - Other bits are ignored.
- i_AV_ByteEn in 4: byte enables for writes.
- i_AV_Read in 1: read strobe.
- o_AV_ReadData out 32: read data.
- i_AV_Write in 1: write strobe.
- i_AV_WriteData in 32: write data.
- o_AV_WaitRequest out 1: stall; the master holds the transfer while this is high.
- i_AV_BurstCount in 11: ignored; every transfer is a single beat.
- o_Tx out 1: serial output, idle high.
- i_Rx in 1: serial input, asynchronous.

## Operation
- CTRL register (address 0):
  - [15:0] DIV, R/W: clocks per bit. A value of 0 behaves as 1.
  - [16] TX_EN, R/W.
  - [17] RX_EN, R/W.
  - [18] TX_BUSY, RO.
  - [19] RX_VALID, RO.
  - [20] RX_OVERRUN, RO.
  - [21] RX_FRAME_ERR, RO.
  - [31:22] read as 0.
  - Writes honor i_AV_ByteEn: byte 0 → DIV[7:0], byte 1 → DIV[15:8], byte 2 → bits [17:16]. Writes to RO bits are ignored.
- DATA register (address 1):
  - Write with ByteEn[0]=1 and TX_EN=1 loads WriteData[7:0] into the transmitter.
  - Write while TX_BUSY: o_AV_WaitRequest is held high until the transmitter is idle, then the write is accepted.
  - Write with TX_EN=0: accepted with no stall and discarded.
  - Read returns {24'b0, rx_byte} and clears RX_VALID, RX_OVERRUN and RX_FRAME_ERR.
- Unselected accesses: o_AV_ReadData=0 and o_AV_WaitRequest=0; no state changes.
- Reads never stall.
- Read and Write both asserted: the write takes priority and read data is 0.
- TX frame format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts DIV clocks.
- TX state machine: IDLE → START → DATA(8 bits) → STOP → IDLE.
- TX_EN cleared mid-frame: the current frame completes.
- DIV changes take effect at the next bit boundary.
- RX path:
  - i_Rx passes through a 2-FF synchronizer.
  - A falling edge in IDLE starts a frame; the start bit is re-checked at DIV/2.
  - If the start bit is high at that check, it is a false start and RX returns to IDLE.
  - Data bits are sampled every DIV clocks after that point.
  - The stop bit is sampled; if it is 0, RX_FRAME_ERR is set and the byte is still stored.
  - Byte complete: RX_VALID=1. If RX_VALID was already 1, RX_OVERRUN=1 and the new byte overwrites the old one.
  - RX_EN=0: RX is held in IDLE.
  - If a DATA read and a byte completion happen in the same cycle, the completion wins: RX_VALID stays 1.

## Timing
- Reset values:
  - o_Tx=1, o_AV_WaitRequest=0, o_AV_ReadData=0.
  - DIV=0, TX_EN=0, RX_EN=0, all status bits 0.
  - Both state machines in IDLE.
- Reset mid-frame aborts the frame; o_Tx goes high on the next edge.
- o_AV_ReadData is combinational from the registers, with zero-wait-state reads.
- Register writes land on the clock edge where Write=1 and WaitRequest=0.
- TX timing for a DATA write accepted at edge N:
  - TX_BUSY=1 and o_Tx=0 (start bit) from edge N.
  - The frame lasts 10×DIV clocks.
  - TX_BUSY falls at the end of the stop bit.
- A DATA write stalled behind a frame is accepted on the first cycle TX_BUSY=0.
- RX_VALID rises 2 synchronizer cycles plus about 9.5×DIV clocks after the start edge.

## Configuration
- UART_RX_EN defined: the receiver and the RX status bits are implemented.
- UART_RX_EN undefined:
  - i_Rx is unused.
  - CTRL[17] and [21:19] read 0 and ignore writes.
  - DATA reads return 0.

## Test plan
- Reset → o_Tx=1, WaitRequest=0, CTRL reads 0.
- Write CTRL=0x0003000A, then DATA=72 (0x48) back-to-back with ByteEn=0xF:
  - Both writes are accepted without stall.
  - o_Tx sequence: 0, then 0,0,0,1,0,0,1,0, then 1, each bit 10 clocks.
  - TX_BUSY is high for 100 clocks.
- Second DATA write (0x55) issued immediately after the first frame starts → WaitRequest is high until the frame ends, then 0x55 is transmitted.
- DATA write with TX_EN=0 → no stall, o_Tx stays 1.
- Loop o_Tx to i_Rx with DIV=10, send 0xA5:
  - RX_VALID=1 and DATA reads 0xA5.
  - The read clears RX_VALID.
  - A second byte received before the read sets RX_OVERRUN.
- Access with the address select field ≠ PERIPH_SEL → ReadData=0, registers unchanged.
